// File: rtl/stopwatch_counter_pkg.sv
// Shared watch definitions: FSM state encoding and default timing constants.
package stopwatch_counter_pkg;

    // Default clk cycles per millisecond tick (50 MHz clock).
    localparam int unsigned DefaultClkDiv   = 50000;
    // Last millisecond value before wrap: 9:59:59.999.
    localparam int unsigned DefaultMaxCount = 35999999;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StRunning = 2'd1,
        StPaused  = 2'd2
    } state_e;

endpackage

// File: rtl/edge_detect.sv
// Registers a synchronous level and flags the cycle where it first goes high.
module edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic pulse
);

    logic prev_q;

    // Remember last cycle's level; cleared by reset so a level held through
    // reset yields one edge on the first cycle afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= din;
        end
    end

    assign pulse = din & ~prev_q;

endmodule

// File: rtl/stopwatch_counter.sv
// Millisecond stopwatch: run/pause/clear FSM, prescaled ms counter with wrap,
// and lap capture of the pre-increment count.
module stopwatch_counter
    import stopwatch_counter_pkg::*;
#(
    parameter int unsigned CLK_DIV   = DefaultClkDiv,
    parameter int unsigned BITS      = 26,
    parameter int unsigned MAX_COUNT = DefaultMaxCount
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_stop,
    input  logic            clear,
    input  logic            lap,
    output logic [BITS-1:0] count,
    output logic [BITS-1:0] lap_count,
    output logic            lap_valid,
    output logic            running,
    output logic            wrap
);

    localparam int unsigned PreW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PreW-1:0] PreMax   = PreW'(CLK_DIV - 1);
    localparam logic [BITS-1:0] CountMax = BITS'(MAX_COUNT);

    state_e            state_q, state_d;
    logic [PreW-1:0]   pre_q, pre_d;
    logic [BITS-1:0]   count_q, count_d;
    logic [BITS-1:0]   lap_count_q, lap_count_d;
    logic              lap_valid_q, lap_valid_d;
    logic              wrap_q, wrap_d;
    logic              running_q;
    logic              ss_edge, lap_edge;

    edge_detect u_ss_edge (
        .clk   (clk),
        .reset (reset),
        .din   (start_stop),
        .pulse (ss_edge)
    );

    edge_detect u_lap_edge (
        .clk   (clk),
        .reset (reset),
        .din   (lap),
        .pulse (lap_edge)
    );

    // Next-state, prescaler/count advance, and lap capture.
    always_comb begin
        state_d     = state_q;
        pre_d       = pre_q;
        count_d     = count_q;
        lap_count_d = lap_count_q;
        lap_valid_d = 1'b0;
        wrap_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (clear) begin
                    pre_d   = '0;
                    count_d = '0;
                end else if (ss_edge) begin
                    state_d = StRunning;
                    pre_d   = '0;
                end
            end
            StRunning: begin
                // A pause edge freezes everything, including a tick due now.
                if (ss_edge) begin
                    state_d = StPaused;
                end else if (pre_q == PreMax) begin
                    pre_d = '0;
                    if (count_q == CountMax) begin
                        count_d = '0;
                        wrap_d  = 1'b1;
                    end else begin
                        count_d = count_q + BITS'(1);
                    end
                end else begin
                    pre_d = pre_q + PreW'(1);
                end
            end
            StPaused: begin
                // Clear outranks resume; resuming keeps the partial ms.
                if (clear) begin
                    state_d = StIdle;
                    pre_d   = '0;
                    count_d = '0;
                end else if (ss_edge) begin
                    state_d = StRunning;
                end
            end
            default: begin
                state_d = StIdle;
                pre_d   = '0;
                count_d = '0;
            end
        endcase

        if (lap_edge && (state_q != StIdle)) begin
            lap_count_d = count_q;
            lap_valid_d = 1'b1;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            pre_q       <= '0;
            count_q     <= '0;
            lap_count_q <= '0;
            lap_valid_q <= 1'b0;
            wrap_q      <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pre_q       <= pre_d;
            count_q     <= count_d;
            lap_count_q <= lap_count_d;
            lap_valid_q <= lap_valid_d;
            wrap_q      <= wrap_d;
            running_q   <= (state_d == StRunning);
        end
    end

    assign count     = count_q;
    assign lap_count = lap_count_q;
    assign lap_valid = lap_valid_q;
    assign running   = running_q;
    assign wrap      = wrap_q;

endmodule
